led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern engine for the SoCFPGA Top, next generation of the
//  board's single-LED blinker. Generates N_LEDS-wide off/blink/chase/count
//  patterns at a programmable tick rate, selected by board switches.
//  A debounced push-button (KEY, active-low) toggles pause/run. Sits between
//  Top's reset/clock logic and the LED pins.
// PARAMETERS
//  N_LEDS        8           LED outputs (>=2)
//  CLK_HZ        50_000_000  sys_clk frequency
//  TICK_HZ       4           pattern step rate; DIV = CLK_HZ/TICK_HZ (>=2, elab assert)
//  DEBOUNCE_CYC  1_000_000   stable cycles required to accept a new button level (>=1)
// PORTS
//  sys_clk   in   1       system clock (FPGA_CLK1_50 domain)
//  sys_rst   in   1       synchronous reset, active-high
//  mode      in   2       00 OFF, 01 BLINK, 10 CHASE, 11 COUNT (from SW[1:0])
//  dir       in   1       CHASE direction: 0 toward MSB, 1 toward LSB (SW[2])
//  pause_n   in   1       raw button, active-low, asynchronous (KEY[1])
//  led       out  N_LEDS  registered pattern output
//  tick      out  1       one-cycle step strobe (debug)
//  paused    out  1       1 = pattern frozen
// BEHAVIOUR
//  Reset (sampled on sys_clk edge while sys_rst=1): led=0, tick=0, paused=0,
//   prescaler=0, blink=0, chase=1 (bit0), count=0, sync/debounce regs=1 (released).
//   Reset mid-operation: all state returns to reset values at that edge.
//  Prescaler: counts 0..DIV-1; tick=1 for exactly the cycle where count==DIV-1,
//   then wraps to 0. While paused: prescaler holds, tick forced 0.
//  Button: pause_n -> 2-FF synchroniser -> debouncer. Debounced level changes
//   only after synced level differs from it for DEBOUNCE_CYC consecutive cycles;
//   any bounce restarts the count. Debounced 1->0 edge (press) toggles paused.
//   Release has no effect. Press in same cycle as tick: tick still applied,
//   pause effective from next cycle.
//  Pattern state advances only on tick, independent of mode (all kept live):
//   blink  <= ~blink
//   chase  <= rotate by 1 (dir=0: left, MSB wraps to bit0; dir=1: right, bit0 wraps to MSB)
//   count  <= count+1 mod 2^N_LEDS
//  Output: led registered from current mode and state, 1-cycle latency:
//   OFF: 0; BLINK: all bits = blink; CHASE: chase; COUNT: count.
//   Mode change: led shows new mode's state the next cycle; no state reset.
//   dir change takes effect at next tick.
//  Invariant: chase always exactly one-hot.
// TESTING  (N_LEDS=8, CLK_HZ=16, TICK_HZ=4 -> DIV=4, DEBOUNCE_CYC=3)
//  1 sys_rst=1 for 2 cycles -> led=0x00, tick=0, paused=0.
//    Release with mode=10 -> led=0x01 one cycle later.
//  2 mode=10 dir=0 -> led 01,02,04..80,01; one step per 4 cycles, tick period 4.
//    dir=1 -> 80,40..01,80.
//  3 mode=11 from reset -> led=0x05 after 5 ticks; 0x00 after 256 ticks (wrap).
//  4 pause_n low 2 cycles -> paused stays 0.
//    pause_n low 10 cycles -> paused=1, tick=0, led frozen.
//    Second 10-cycle press -> paused=0, steps resume from frozen value.
//  5 mode=01 -> led alternates FF/00 per tick. mode=00 -> led=00 next cycle.
//    mode=10 -> chase position advanced by ticks elapsed meanwhile.
//  6 sys_rst pulse while CHASE led=0x10 -> led=0x00 at that edge, then 0x01;
//    prescaler restarts (next tick 4 cycles after release).

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern engine: a tick prescaler, a debounced pause button and
// blink/chase/count pattern state, with a registered output multiplexer
// that selects the pattern to show.
module led_pattern_gen #(
    parameter int N_LEDS       = 8,
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 4,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic              pause_n,
    output logic [N_LEDS-1:0] led,
    output logic              tick,
    output logic              paused
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_CHASE = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (N_LEDS < 2) begin : g_bad_nleds
            $error("led_pattern_gen: N_LEDS must be at least 2");
        end
        if (DEBOUNCE_CYC < 1) begin : g_bad_deb
            $error("led_pattern_gen: DEBOUNCE_CYC must be at least 1");
        end
    endgenerate

    logic [PW-1:0]     presc_q, presc_d;
    logic              paused_q, paused_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              deb_q, deb_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              blink_q, blink_d;
    logic [N_LEDS-1:0] chase_q, chase_d;
    logic [N_LEDS-1:0] count_q, count_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              tick_w;
    logic              press_w;

    // Step strobe: last prescaler count, suppressed while frozen.
    always_comb begin
        tick_w = (presc_q == PW'(DIV - 1)) && !paused_q;
    end

    // Prescaler holds its count while paused so a resume continues the same period.
    always_comb begin
        presc_d = presc_q;
        if (!paused_q) begin
            if (tick_w) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Button path: two-flop synchroniser, then a debouncer that restarts on any bounce.
    always_comb begin
        sync1_d = pause_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        dcnt_d  = '0;
        press_w = 1'b0;
        if (sync2_q != deb_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                deb_d   = sync2_q;
                press_w = ~sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
        paused_d = paused_q ^ press_w;
    end

    // All three patterns stay live and advance on every tick regardless of mode.
    always_comb begin
        blink_d = blink_q;
        chase_d = chase_q;
        count_d = count_q;
        if (tick_w) begin
            blink_d = ~blink_q;
            if (dir) begin
                chase_d = {chase_q[0], chase_q[N_LEDS-1:1]};
            end else begin
                chase_d = {chase_q[N_LEDS-2:0], chase_q[N_LEDS-1]};
            end
            count_d = count_q + N_LEDS'(1);
        end
    end

    // Output mux from current mode and pattern state, registered below.
    always_comb begin
        led_d = '0;
        case (mode_e'(mode))
            MODE_OFF:   led_d = '0;
            MODE_BLINK: led_d = {N_LEDS{blink_q}};
            MODE_CHASE: led_d = chase_q;
            MODE_COUNT: led_d = count_q;
            default:    led_d = '0;
        endcase
    end

    // State registers; the button chain resets to the released (high) level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q  <= '0;
            paused_q <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b1;
            dcnt_q   <= '0;
            blink_q  <= 1'b0;
            chase_q  <= N_LEDS'(1);
            count_q  <= '0;
            led_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            paused_q <= paused_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            blink_q  <= blink_d;
            chase_q  <= chase_d;
            count_q  <= count_d;
            led_q    <= led_d;
        end
    end

    assign led    = led_q;
    assign tick   = tick_w;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a behavioural reference model.
module tb_led_pattern_gen;

    localparam int N    = 8;
    localparam int CHZ  = 16;
    localparam int THZ  = 4;
    localparam int DEB  = 3;
    localparam int DIV  = CHZ / THZ;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic       pause_n = 1'b1;
    logic [N-1:0] led;
    logic       tick;
    logic       paused;

    int checks = 0;
    int failures = 0;

    // Reference model: step counts and positions, not register images.
    int   m_presc;
    int   m_count;
    int   m_pos;
    int   m_run;
    bit   m_paused;
    bit   m_blink;
    bit   m_s1, m_s2, m_deb;
    logic [N-1:0] m_led;

    led_pattern_gen #(
        .N_LEDS(N), .CLK_HZ(CHZ), .TICK_HZ(THZ), .DEBOUNCE_CYC(DEB)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .mode(mode), .dir(dir),
        .pause_n(pause_n), .led(led), .tick(tick), .paused(paused)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] pattern(input logic [1:0] md);
        logic [N-1:0] p;
        case (md)
            2'b00: p = '0;
            2'b01: p = m_blink ? {N{1'b1}} : '0;
            2'b10: p = N'(1) << m_pos;
            default: p = N'(m_count);
        endcase
        return p;
    endfunction

    function automatic bit exp_tick();
        return (m_presc == DIV - 1) && !m_paused;
    endfunction

    // Advance one clock edge and move the model by the same edge.
    task automatic cycle();
        bit t;
        bit old_paused;
        logic [N-1:0] nl;
        @(posedge clk);
        if (rst) begin
            m_presc = 0; m_count = 0; m_pos = 0; m_run = 0;
            m_paused = 0; m_blink = 0;
            m_s1 = 1; m_s2 = 1; m_deb = 1;
            m_led = '0;
        end else begin
            t = exp_tick();
            old_paused = m_paused;
            nl = pattern(mode);
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb = m_s2;
                    m_run = 0;
                    if (!m_deb) m_paused = !m_paused;
                end
            end else begin
                m_run = 0;
            end
            if (!old_paused) m_presc = (m_presc + 1) % DIV;
            if (t) begin
                m_blink = !m_blink;
                m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                m_count = (m_count + 1) % (1 << N);
            end
            m_s2 = m_s1;
            m_s1 = pause_n;
            m_led = nl;
        end
        #1;
    endtask

    task automatic do_reset(input logic [1:0] md);
        rst = 1'b1;
        mode = md;
        pause_n = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 2'b10;
        dir = 1'b0;
        cycle();
        cycle();
        checks++;
        if (led !== 8'h00 || tick !== 1'b0 || paused !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: led=%h tick=%b paused=%b, want 00 0 0", led, tick, paused);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (led !== 8'h01) begin
            failures++;
            $display("FAIL reset_release_led: led=%h, want 01", led);
        end
    endtask

    task automatic test_chase();
        int nt;
        do_reset(2'b10);
        for (int d = 0; d < 2; d++) begin
            dir = d[0];
            nt = 0;
            for (int i = 0; i < 40; i++) begin
                cycle();
                if (tick === 1'b1) nt++;
                checks++;
                if (led !== m_led || tick !== exp_tick()) begin
                    failures++;
                    $display("FAIL chase_dir%0d cyc%0d: led=%h tick=%b, want %h %b",
                             d, i, led, tick, m_led, exp_tick());
                end
            end
            checks++;
            if (nt != 40 / DIV) begin
                failures++;
                $display("FAIL chase_tick_rate dir%0d: ticks=%0d, want %0d", d, nt, 40 / DIV);
            end
        end
    endtask

    task automatic test_count();
        int nt;
        int budget;
        do_reset(2'b11);
        nt = 0;
        budget = 0;
        while (nt < 256 && budget < 2000) begin
            cycle();
            budget++;
            checks++;
            if (led !== m_led || tick !== exp_tick()) begin
                failures++;
                $display("FAIL count_track: led=%h tick=%b, want %h %b", led, tick, m_led, exp_tick());
            end
            if (tick === 1'b1) begin
                nt++;
                if (nt == 5 || nt == 256) begin
                    cycle();
                    cycle();
                    checks++;
                    if (led !== ((nt == 5) ? 8'h05 : 8'h00)) begin
                        failures++;
                        $display("FAIL count_after_%0d_ticks: led=%h, want %h",
                                 nt, led, (nt == 5) ? 8'h05 : 8'h00);
                    end
                end
            end
        end
        checks++;
        if (nt != 256) begin
            failures++;
            $display("FAIL count_timeout: ticks=%0d, want 256", nt);
        end
    endtask

    task automatic press(input int len);
        pause_n = 1'b0;
        for (int i = 0; i < len; i++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== exp_tick() || paused !== m_paused) begin
                failures++;
                $display("FAIL press_track: led=%h tick=%b paused=%b, want %h %b %b",
                         led, tick, paused, m_led, exp_tick(), m_paused);
            end
        end
        pause_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== exp_tick() || paused !== m_paused) begin
                failures++;
                $display("FAIL release_track: led=%h tick=%b paused=%b, want %h %b %b",
                         led, tick, paused, m_led, exp_tick(), m_paused);
            end
        end
    endtask

    task automatic test_pause();
        logic [N-1:0] frozen;
        do_reset(2'b11);
        for (int i = 0; i < 9; i++) cycle();
        press(2);
        checks++;
        if (paused !== 1'b0) begin
            failures++;
            $display("FAIL pause_short_glitch: paused=%b, want 0", paused);
        end
        press(10);
        checks++;
        if (paused !== 1'b1) begin
            failures++;
            $display("FAIL pause_engaged: paused=%b, want 1", paused);
        end
        frozen = led;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (led !== frozen || tick !== 1'b0) begin
                failures++;
                $display("FAIL pause_frozen: led=%h tick=%b, want %h 0", led, tick, frozen);
            end
        end
        press(10);
        checks++;
        if (paused !== 1'b0) begin
            failures++;
            $display("FAIL pause_resume: paused=%b, want 0", paused);
        end
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (led !== m_led || tick !== exp_tick()) begin
                failures++;
                $display("FAIL resume_track: led=%h tick=%b, want %h %b", led, tick, m_led, exp_tick());
            end
        end
    endtask

    task automatic test_modes();
        logic [N-1:0] prev;
        int nt;
        do_reset(2'b01);
        nt = 0;
        prev = 8'h00;
        for (int i = 0; i < 24; i++) begin
            cycle();
            checks++;
            if (led !== m_led || (led !== 8'hFF && led !== 8'h00)) begin
                failures++;
                $display("FAIL blink_track: led=%h, want %h", led, m_led);
            end
            if (tick === 1'b1) nt++;
        end
        mode = 2'b00;
        cycle();
        cycle();
        checks++;
        if (led !== 8'h00) begin
            failures++;
            $display("FAIL off_mode: led=%h, want 00", led);
        end
        for (int i = 0; i < 13; i++) cycle();
        mode = 2'b10;
        cycle();
        cycle();
        prev = N'(1) << ((nt + 0) % N);
        checks++;
        if (led !== m_led) begin
            failures++;
            $display("FAIL chase_after_off: led=%h, want %h", led, m_led);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        do_reset(2'b10);
        dir = 1'b0;
        budget = 0;
        while (led !== 8'h10 && budget < 200) begin
            cycle();
            budget++;
        end
        checks++;
        if (led !== 8'h10) begin
            failures++;
            $display("FAIL midreset_reach: led=%h, want 10", led);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (led !== 8'h00 || tick !== 1'b0 || paused !== 1'b0) begin
            failures++;
            $display("FAIL midreset_edge: led=%h tick=%b paused=%b, want 00 0 0", led, tick, paused);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (led !== 8'h01 || tick !== (i == 3)) begin
                failures++;
                $display("FAIL midreset_cyc%0d: led=%h tick=%b, want 01 %b", i, led, tick, (i == 3));
            end
        end
    endtask

    task automatic test_random();
        int hold_m, hold_b;
        do_reset(2'($urandom_range(0, 3)));
        hold_m = 0;
        hold_b = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold_m == 0) begin
                mode = 2'($urandom_range(0, 3));
                dir = 1'($urandom_range(0, 1));
                hold_m = $urandom_range(1, 30);
            end
            if (hold_b == 0) begin
                pause_n = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 12);
            end
            hold_m--;
            hold_b--;
            cycle();
            checks++;
            if (led !== m_led || tick !== exp_tick() || paused !== m_paused) begin
                failures++;
                $display("FAIL random cyc%0d: led=%h tick=%b paused=%b, want %h %b %b",
                         i, led, tick, paused, m_led, exp_tick(), m_paused);
            end
        end
        pause_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_chase();
        test_count();
        test_pause();
        test_modes();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
